// File: rtl/hex_scroll_display.sv
// hex_scroll_display
//   Multi-digit active-low seven-segment driver. Holds a MSG_DIGITS-nibble
//   message loaded over a valid/ready port and shows a NUM_DIGITS window of
//   it, either static (offset 0) or rotating one digit per TICK_DIV enabled
//   clocks.
//
//   Ports:
//     clock, resetn        clock, synchronous active-low reset
//     load_valid/ready     message load handshake (transfer = valid & ready)
//     load_data            message, nibble j at [4j+3:4j]
//     mode                 0 static, 1 scroll (captured on a transfer)
//     enable               scroll run/pause
//     HEX                  digit i at [7i+6:7i], active-low, bit0 = seg a
//
//   Optional feature: define HEX_LEADING_BLANK_EN to blank leading zero
//   digits while the display is static.

module hex_seg_lane (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    case (nib)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
  end
endmodule

module hex_scroll_display #(
  parameter int MSG_DIGITS = 8,
  parameter int NUM_DIGITS = 6,
  parameter int TICK_DIV   = 50000000
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*MSG_DIGITS-1:0] load_data,
  input  logic                    mode,
  input  logic                    enable,
  output logic [7*NUM_DIGITS-1:0] HEX
);
  localparam int OW = (MSG_DIGITS > 1) ? $clog2(MSG_DIGITS) : 1;
  localparam int DW = $clog2(TICK_DIV);
`ifdef HEX_LEADING_BLANK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, LOAD, SHOW, SCROLL} state_t;

  state_t                           state;
  logic [MSG_DIGITS-1:0][3:0]       msg;
  logic                             mode_q;
  logic [OW-1:0]                    offset;
  logic [DW-1:0]                    div;
  logic [NUM_DIGITS-1:0][3:0]       win;
  logic [NUM_DIGITS-1:0][6:0]       seg_c, seg_d, hex_q;
  logic [NUM_DIGITS-1:0]            lead;
  logic                             xfer;

  // Ready depends only on state and reset, never on load_valid.
  assign load_ready = resetn & (state != LOAD);
  assign xfer       = load_valid & load_ready;
  assign HEX        = hex_q;

  // Window select: digit i <- nibble (offset + i) mod MSG_DIGITS. The sum is
  // below 2*MSG_DIGITS, so a single conditional subtract wraps it.
  always_comb begin
    logic [OW:0] s;
    win = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      s = {1'b0, offset} + (OW+1)'(i);
      if (s >= (OW+1)'(MSG_DIGITS)) s = s - (OW+1)'(MSG_DIGITS);
      win[i] = msg[s[OW-1:0]];
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    hex_seg_lane u_lane (.nib(win[g]), .seg(seg_c[g]));
  end

  // lead[i]: digit i and every digit above it are zero; digit 0 never blanks.
  always_comb begin
    logic z;
    z    = 1'b1;
    lead = '0;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      z       = z & (win[i] == 4'h0);
      lead[i] = z & (i != 0);
    end
  end

  always_comb begin
    seg_d = seg_c;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (LB && state == SHOW && lead[i]) seg_d[i] = 7'h7F;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state  <= IDLE;
      msg    <= '0;
      mode_q <= 1'b0;
      offset <= '0;
      div    <= '0;
      hex_q  <= '1;
    end else begin
      // A transfer takes priority over a tick in the same cycle.
      if (xfer) begin
        msg    <= load_data;
        mode_q <= mode;
        offset <= '0;
        div    <= '0;
        state  <= LOAD;
      end else begin
        case (state)
          LOAD:   state <= mode_q ? SCROLL : SHOW;
          SCROLL: if (enable) begin
            if (div == DW'(TICK_DIV-1)) begin
              div    <= '0;
              offset <= (offset == OW'(MSG_DIGITS-1)) ? '0 : offset + OW'(1);
            end else begin
              div <= div + DW'(1);
            end
          end
          default: ;
        endcase
      end
      // Display follows the current state one edge later; LOAD holds the old
      // picture so the new window appears two edges after the transfer.
      case (state)
        IDLE:    hex_q <= '1;
        LOAD:    hex_q <= hex_q;
        default: hex_q <= seg_d;
      endcase
    end
  end
endmodule

// File: tb/tb_hex_scroll_display.sv
module tb_hex_scroll_display;
  localparam int MSG = 8, NUM = 6, TD = 4;
`ifdef HEX_LEADING_BLANK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif
  localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [41:0] ALL7F = {6{7'h7F}};
  localparam logic [41:0] S1    = {7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  localparam logic [41:0] SC1   = {7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06};
  localparam logic [41:0] C1    = {7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
  localparam logic [41:0] OFF5  = {7'h21, 7'h06, 7'h0E, 7'h00, 7'h10, 7'h08};
  localparam logic [41:0] LEADV = LB ? {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h24, 7'h40}
                                     : {7'h40, 7'h40, 7'h40, 7'h79, 7'h24, 7'h40};

  logic        clock = 1'b0, resetn = 1'b0, load_valid = 1'b0, mode = 1'b0, enable = 1'b0;
  logic [31:0] load_data = '0;
  logic        load_ready;
  logic [41:0] HEX;

  always #5 clock = ~clock;

  hex_scroll_display #(.MSG_DIGITS(MSG), .NUM_DIGITS(NUM), .TICK_DIV(TD)) dut (
    .clock(clock), .resetn(resetn), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .mode(mode), .enable(enable), .HEX(HEX));

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [41:0] act, input logic [41:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: offset is derived from the count of enabled SCROLL
  // cycles since the last load, rather than from a divider.
  typedef enum {M_IDLE, M_LOAD, M_SHOW, M_SCROLL} mph_t;
  mph_t        ph = M_IDLE;
  logic [3:0]  mm [MSG];
  bit          mmode = 1'b0;
  int          ecnt = 0;
  logic [41:0] exp_hex = '1;
  bit          exp_rdy = 1'b0;
  bit          chk_on = 1'b0;

  function automatic logic [41:0] window();
    logic [41:0] r;
    logic [3:0]  n [NUM];
    int off, h;
    off = (ecnt / TD) % MSG;
    h = 0;
    for (int i = 0; i < NUM; i++) begin
      n[i] = mm[(off + i) % MSG];
      if (n[i] != 4'h0) h = i;
    end
    for (int i = 0; i < NUM; i++)
      r[7*i +: 7] = (LB && ph == M_SHOW && i > h) ? 7'h7F : SEG[n[i]];
    return r;
  endfunction

  always @(posedge clock) begin
    logic [41:0] nh;
    case (ph)
      M_IDLE:  nh = '1;
      M_LOAD:  nh = exp_hex;
      default: nh = window();
    endcase
    if (!resetn) begin
      ph = M_IDLE; mmode = 1'b0; ecnt = 0; nh = '1; chk_on = 1'b1;
      for (int j = 0; j < MSG; j++) mm[j] = 4'h0;
    end else if (load_valid && ph != M_LOAD) begin
      for (int j = 0; j < MSG; j++) mm[j] = load_data[4*j +: 4];
      mmode = mode; ecnt = 0; ph = M_LOAD;
    end else if (ph == M_LOAD) begin
      ph = mmode ? M_SCROLL : M_SHOW;
    end else if (ph == M_SCROLL && enable) begin
      ecnt++;
    end
    exp_hex = nh;
    exp_rdy = (ph != M_LOAD);
  end

  always @(negedge clock) begin
    if (chk_on) begin
      chk("hex_model", HEX, exp_hex);
      chk("ready_model", 42'(load_ready), 42'(exp_rdy & resetn));
    end
  end

  task automatic adv(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic load(input logic [31:0] d, input bit m);
    load_valid = 1'b1; load_data = d; mode = m;
    adv(1);
    load_valid = 1'b0;
  endtask

  initial begin
    // Reset
    resetn = 1'b0;
    adv(2);
    chk("rst_hex", HEX, ALL7F);
    chk("rst_ready", 42'(load_ready), 42'(0));
    resetn = 1'b1;
    #1;
    chk("ready_after_rst", 42'(load_ready), 42'(1));
    adv(1);
    chk("idle_hex", HEX, ALL7F);

    // Static load
    load(32'h89ABCDEF, 1'b0);
    adv(2);
    chk("static", HEX, S1);
    adv(10);
    chk("static_hold", HEX, S1);

    // Scroll: first tick, then full wrap after 8 ticks
    enable = 1'b1;
    load(32'h89ABCDEF, 1'b1);
    adv(6);
    chk("scroll_tick1", HEX, SC1);
    adv(28);
    chk("scroll_wrap", HEX, S1);

    // Pause with the divider mid-count, then resume
    adv(1);
    enable = 1'b0;
    adv(10);
    chk("pause_hold", HEX, S1);
    enable = 1'b1;
    adv(2);
    chk("pre_tick", HEX, S1);
    adv(1);
    chk("resume_tick", HEX, SC1);

    // Load coinciding with a tick
    load(32'h89ABCDEF, 1'b1);
    adv(4);
    load(32'h01234567, 1'b0);
    adv(2);
    chk("collision", HEX, C1);

    // Reset mid-scroll at offset 5
    load(32'h89ABCDEF, 1'b1);
    adv(22);
    chk("offset5", HEX, OFF5);
    resetn = 1'b0;
    adv(1);
    chk("midrst_hex", HEX, ALL7F);
    chk("midrst_ready", 42'(load_ready), 42'(0));
    resetn = 1'b1;
    adv(2);
    chk("post_midrst_idle", HEX, ALL7F);

    // Leading-zero handling
    load(32'h00000120, 1'b0);
    adv(2);
    chk("leading", HEX, LEADV);

    // Randomized traffic against the model
    repeat (400) begin
      load_valid = ($urandom_range(0, 7) == 0);
      load_data  = ($urandom_range(0, 2) == 0) ? ($urandom & 32'h00000FFF) : $urandom;
      mode       = $urandom_range(0, 1) == 1;
      enable     = ($urandom_range(0, 3) != 0);
      resetn     = ($urandom_range(0, 149) != 0);
      adv(1);
    end
    resetn = 1'b1; load_valid = 1'b0;
    adv(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/hex_scroll_display.md
# hex_scroll_display

Parametrised multi-digit seven-segment display driver. It is the clocked successor to the single-digit combinational hex decoder. It holds a message of up to `MSG_DIGITS` hex nibbles, accepted through a valid/ready load port, and drives `NUM_DIGITS` active-low seven-segment displays. The display shows either a static window or a window that rotates continuously at a programmable rate. It sits between board-level switch/key logic and the DE1-SoC `HEX` outputs.

## Interface
- `MSG_DIGITS`, 8: message length in hex nibbles; must be ≥ `NUM_DIGITS`.
- `NUM_DIGITS`, 6: number of physical seven-segment digits driven.
- `TICK_DIV`, 50000000: clock cycles per scroll step; must be ≥ 2.
- `clock`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  reset, synchronous and active-low.
- `load_valid`  in  1  a new message is presented on `load_data`.
- `load_ready`  out  1  the block accepts a message this cycle.
- `load_data`  in  4*MSG_DIGITS  message; nibble j is `load_data[4j+3:4j]`.
- `mode`  in  1  0 = static, 1 = scroll; sampled only on a load transfer.
- `enable`  in  1  1 = scrolling runs, 0 = scrolling pauses; ignored outside SCROLL.
- `HEX`  out  7*NUM_DIGITS  digit i on `HEX[7i+6:7i]`; active-low; bit 0 = segment a … bit 6 = segment g; digit 0 is the rightmost.

## Operation
- **States:** IDLE, LOAD, SHOW, SCROLL.
- **Transfer:** a transfer occurs when `load_valid & load_ready` at a clock edge.
  - The edge stores `load_data` into the message register and `mode` into the mode register.
  - It clears `offset` and the divider, and moves the state to LOAD.
- **`load_ready`:** 1 in IDLE, SHOW and SCROLL; 0 in LOAD and while `resetn` = 0.
- **LOAD:** lasts exactly one cycle, then moves to SHOW if the stored mode is 0, or to SCROLL if it is 1.
- **Digit mapping:** display digit i shows message nibble `(offset + i) mod MSG_DIGITS`.
- **SHOW:** `offset` stays at 0.
- **SCROLL:**
  - The divider counts 0…`TICK_DIV`-1 while `enable` = 1 and holds its value while `enable` = 0.
  - When the divider = `TICK_DIV`-1 and `enable` = 1 (a tick), the divider returns to 0 and `offset` increments.
  - `offset` wraps from `MSG_DIGITS`-1 to 0.
  - Net effect: the content moves one digit rightward per tick.
- **IDLE:** all digits blank (7'h7F).
- **Segment codes** (active-low, g…a), nibbles 0–F in order: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
- **Arithmetic:**
  - `offset` is `$clog2(MSG_DIGITS)` bits wide; modulo arithmetic uses explicit compare-and-wrap, with no reliance on power-of-two sizes.
  - The divider is `$clog2(TICK_DIV)` bits wide.
- **Boundary rules:**
  - A transfer and a tick in the same cycle: the transfer wins (`offset` = 0, divider = 0).
  - A new load is accepted in SHOW or SCROLL at any time; the previous message is discarded.
  - `enable` falling mid-count pauses the divider; on resume, counting continues from the held value.
  - `MSG_DIGITS` = `NUM_DIGITS` is legal; scrolling is then a pure rotation.

## Timing
- **Reset** (`resetn` = 0 at an edge):
  - state = IDLE; message = 0; mode = 0; `offset` = 0; divider = 0.
  - `HEX` = all ones (every digit 7'h7F).
  - `load_ready` reads 0 during reset and 1 in the first cycle after `resetn` returns high.
- **Reset mid-operation:** identical to power-on reset. The display blanks on the next edge, and nothing is retained.
- **`HEX` is registered:** it reflects state, `offset` and message one edge after they change.
- **Load latency:**
  - Transfer at edge k → LOAD during cycle k..k+1.
  - SHOW/SCROLL is entered at edge k+1, and `HEX` shows the new window from edge k+2.
- **Scroll timing:**
  - The first tick occurs `TICK_DIV` enabled cycles after entering SCROLL.
  - `HEX` changes one edge after each tick.
- **Load port:** no combinational path from `load_valid` to `load_ready`.

## Configuration
- **`HEX_LEADING_BLANK_EN` defined:**
  - In SHOW only, displayed digits that are zero and lie above the most significant displayed nonzero digit output 7'h7F.
  - Digit 0 is always shown.
  - SCROLL and IDLE are unaffected.
- **Undefined:** every displayed digit shows its segment code, including leading zeros.

## Test plan
Bench parameters: `MSG_DIGITS` = 8, `NUM_DIGITS` = 6, `TICK_DIV` = 4.

- **Reset:** hold `resetn` = 0 for 2 cycles → `HEX` = 42'h3FF_FFFF_FFFF and `load_ready` = 0; release → `load_ready` = 1, state IDLE, `HEX` still all 7F.
- **Static load:** load 32'h89ABCDEF with `mode` = 0 → two edges after the transfer, HEX0..HEX5 = 0E, 06, 21, 46, 03, 08. Values are held indefinitely.
- **Scroll:** same data with `mode` = 1 and `enable` = 1 → after 4 cycles in SCROLL, the next edge shows HEX0..HEX5 = 06, 21, 46, 03, 08, 10. After 8 ticks, the initial window returns (wrap).
- **Pause and collision:**
  - `enable` = 0 for 10 cycles mid-count → no `HEX` change; resume → the tick arrives after the remaining count.
  - A load coinciding with a tick → `offset` = 0, and the new message is shown.
- **Reset mid-scroll:** assert reset during SCROLL at `offset` 5 → the next edge gives all 7F, IDLE, `offset` 0.
- **Leading blank:** load 32'h00000120 with `mode` = 0.
  - With `HEX_LEADING_BLANK_EN`: HEX5..HEX3 = 7F, HEX2 = 79, HEX1 = 24, HEX0 = 40.
  - Without it: HEX5..HEX3 = 40, with HEX2..HEX0 unchanged.
